// File: rtl/timer_pkg.sv
// Shared types and constants for the timing subsystem (countdown timer and stopwatch).
//   timer_state_e     : controller state encoding
//   MaxMin/MaxSec/... : legal upper bounds of the time fields
//   sat_field()       : clamps a preset field to its legal maximum
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } timer_state_e;

  localparam logic [7:0]  MaxMin = 8'd59;
  localparam logic [7:0]  MaxSec = 8'd59;
  localparam logic [15:0] MaxMs  = 16'd999;

  // 50 MHz system clock
  localparam int unsigned DefaultTicksPerMs = 50000;

  function automatic logic [15:0] sat_field(input logic [15:0] val, input logic [15:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Host-side control/status bundle of the countdown timer.
//   master : host drives load/preset/start/pause/clear, reads remaining time and status
//   slave  : timer side
interface countdown_timer_if;

  logic        load;
  logic [7:0]  load_min;
  logic [7:0]  load_sec;
  logic [15:0] load_ms;
  logic        start;
  logic        pause;
  logic        clear;
  logic [7:0]  minute;
  logic [7:0]  second;
  logic [15:0] msecond;
  logic        busy;
  logic        done;
  logic        expired;

  modport master (
    output load, load_min, load_sec, load_ms, start, pause, clear,
    input  minute, second, msecond, busy, done, expired
  );

  modport slave (
    input  load, load_min, load_sec, load_ms, start, pause, clear,
    output minute, second, msecond, busy, done, expired
  );

endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler.
//   clk, rst : clock, asynchronous active-low reset
//   en       : count this cycle
//   clr      : synchronous return of the prescaler to 0 (wins over en)
//   tick     : high on the enabled cycle that completes TICKS_PER_MS enabled cycles
// TICKS_PER_MS must fit in CNT_W bits (2**CNT_W > TICKS_PER_MS).
module ms_tick_gen
  import timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS = DefaultTicksPerMs,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TICKS_PER_MS - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == LastCnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Minute/second/millisecond countdown timer.
//   clk, rst : 50 MHz clock, asynchronous active-low reset
//   bus      : host interface (countdown_timer_if.slave)
//     load + load_min/sec/ms : preset, saturated to 59:59:999, accepted in IDLE or DONE
//     start                  : begin countdown from IDLE (zero preset expires at once)
//     pause                  : level, freezes the countdown while high
//     clear                  : abort to IDLE with zero counts
//     minute/second/msecond  : remaining time
//     busy / done / expired  : running-or-paused, one-cycle expiry pulse, expired level
// Same-cycle priority: clear > load > start > pause.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS = DefaultTicksPerMs,
  parameter int unsigned CNT_W        = 16
) (
  input logic              clk,
  input logic              rst,
  countdown_timer_if.slave bus
);

  timer_state_e state_q;
  logic [7:0]   min_q;
  logic [7:0]   sec_q;
  logic [15:0]  ms_q;
  logic         busy_q;
  logic         done_q;
  logic         expired_q;

  logic         ms_tick;
  logic         tick_en;
  logic         tick_clr;

  logic [7:0]   dec_min;
  logic [7:0]   dec_sec;
  logic [15:0]  dec_ms;
  logic         dec_zero;
  logic         counts_zero;

  logic [7:0]   preset_min;
  logic [7:0]   preset_sec;
  logic [15:0]  preset_ms;

  // Prescaler only advances in RUN; it is held in PAUSE so a resumed countdown loses no
  // phase, and parked at 0 in IDLE/DONE so the first tick lands TICKS_PER_MS after start.
  assign tick_en  = (state_q == StRun);
  assign tick_clr = bus.clear || (state_q == StIdle) || (state_q == StDone);

  ms_tick_gen #(
    .TICKS_PER_MS(TICKS_PER_MS),
    .CNT_W       (CNT_W)
  ) u_ms_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (tick_en),
    .clr (tick_clr),
    .tick(ms_tick)
  );

  assign preset_min = 8'(sat_field({8'd0, bus.load_min}, {8'd0, MaxMin}));
  assign preset_sec = 8'(sat_field({8'd0, bus.load_sec}, {8'd0, MaxSec}));
  assign preset_ms  = sat_field(bus.load_ms, MaxMs);

  assign counts_zero = (min_q == 8'd0) && (sec_q == 8'd0) && (ms_q == 16'd0);

  // Borrow chain. Only used in RUN, where the counts are never all zero, so the minute
  // borrow cannot underflow.
  always_comb begin
    dec_min = min_q;
    dec_sec = sec_q;
    dec_ms  = ms_q;
    if (ms_q != 16'd0) begin
      dec_ms = ms_q - 16'd1;
    end else if (sec_q != 8'd0) begin
      dec_ms  = MaxMs;
      dec_sec = sec_q - 8'd1;
    end else begin
      dec_ms  = MaxMs;
      dec_sec = MaxSec;
      dec_min = min_q - 8'd1;
    end
  end

  assign dec_zero = (dec_min == 8'd0) && (dec_sec == 8'd0) && (dec_ms == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      min_q     <= '0;
      sec_q     <= '0;
      ms_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.clear) begin
        state_q   <= StIdle;
        min_q     <= '0;
        sec_q     <= '0;
        ms_q      <= '0;
        busy_q    <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.load) begin
              min_q <= preset_min;
              sec_q <= preset_sec;
              ms_q  <= preset_ms;
            end else if (bus.start) begin
              if (counts_zero) begin
                state_q   <= StDone;
                done_q    <= 1'b1;
                expired_q <= 1'b1;
              end else begin
                state_q <= StRun;
                busy_q  <= 1'b1;
              end
            end
          end
          StRun: begin
            if (ms_tick) begin
              min_q <= dec_min;
              sec_q <= dec_sec;
              ms_q  <= dec_ms;
            end
            // Expiry outranks a simultaneous pause request.
            if (ms_tick && dec_zero) begin
              state_q   <= StDone;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              expired_q <= 1'b1;
            end else if (bus.pause) begin
              state_q <= StPause;
            end
          end
          StPause: begin
            if (!bus.pause) begin
              state_q <= StRun;
            end
          end
          StDone: begin
            if (bus.load) begin
              state_q   <= StIdle;
              min_q     <= preset_min;
              sec_q     <= preset_sec;
              ms_q      <= preset_ms;
              expired_q <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign bus.minute  = min_q;
  assign bus.second  = sec_q;
  assign bus.msecond = ms_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer with TICKS_PER_MS = 4. Directed scenarios use constant
// expectations; the random scenario compares against a model that keeps the remaining
// time as a single millisecond total.
module tb_countdown_timer;

  localparam int unsigned T = 4;

  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MPause = 2;
  localparam int MDone  = 3;

  logic clk = 1'b0;
  logic rst;

  countdown_timer_if bus ();

  countdown_timer #(
    .TICKS_PER_MS(T),
    .CNT_W       (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining time in ms, phase within the current millisecond.
  int m_state;
  int m_rem;
  int m_ph;
  bit m_done;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_state = MIdle;
    m_rem   = 0;
    m_ph    = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (bus.clear) begin
      m_state = MIdle;
      m_rem   = 0;
      m_ph    = 0;
    end else if (bus.load && (m_state == MIdle || m_state == MDone)) begin
      m_rem = sat(int'(bus.load_min), 59) * 60000 + sat(int'(bus.load_sec), 59) * 1000
            + sat(int'(bus.load_ms), 999);
      m_state = MIdle;
    end else if (bus.start && m_state == MIdle) begin
      if (m_rem == 0) begin
        m_state = MDone;
        m_done  = 1'b1;
      end else begin
        m_state = MRun;
        m_ph    = 0;
      end
    end else if (m_state == MRun) begin
      if (m_ph == int'(T) - 1) begin
        m_ph  = 0;
        m_rem = m_rem - 1;
      end else begin
        m_ph = m_ph + 1;
      end
      if (m_rem == 0) begin
        m_state = MDone;
        m_done  = 1'b1;
      end else if (bus.pause) begin
        m_state = MPause;
      end
    end else if (m_state == MPause && !bus.pause) begin
      m_state = MRun;
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.load     = 1'b0;
    bus.load_min = 8'd0;
    bus.load_sec = 8'd0;
    bus.load_ms  = 16'd0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic do_load(input int mn, input int sc, input int ms);
    bus.load_min = 8'(mn);
    bus.load_sec = 8'(sc);
    bus.load_ms  = 16'(ms);
    bus.load     = 1'b1;
    clk_step();
    bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    clk_step();
    bus.start = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    clk_step();
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [34:0] got;
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    got = {bus.minute, bus.second, bus.msecond, bus.busy, bus.done, bus.expired};
    checks++;
    if (got !== 35'd0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", got);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    int n;
    bit got;
    do_load(0, 0, 3);
    checks++;
    if ({bus.minute, bus.second, bus.msecond} !== {8'd0, 8'd0, 16'd3}) begin
      failures++;
      $display("FAIL basic_load got=%0d:%0d:%0d want=0:0:3", bus.minute, bus.second, bus.msecond);
    end
    do_start();
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got=%b want=1", bus.busy);
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      clk_step();
      n++;
      if (bus.done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || n != 12) begin
      failures++;
      $display("FAIL basic_done_edge got=%0d (seen=%0b) want=12", n, got);
    end
    checks++;
    if ({bus.minute, bus.second, bus.msecond, bus.busy, bus.expired} !== {32'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL basic_expiry got=%0d:%0d:%0d busy=%b exp=%b want=0:0:0 busy=0 exp=1",
               bus.minute, bus.second, bus.msecond, bus.busy, bus.expired);
    end
    clk_step();
    checks++;
    if ({bus.done, bus.expired} !== 2'b01) begin
      failures++;
      $display("FAIL basic_done_pulse got done=%b exp=%b want done=0 exp=1", bus.done, bus.expired);
    end
  endtask

  task automatic test_borrow_sec();
    int n;
    bit got;
    do_load(0, 1, 0);
    do_start();
    repeat (4) clk_step();
    checks++;
    if ({bus.minute, bus.second, bus.msecond} !== {8'd0, 8'd0, 16'd999}) begin
      failures++;
      $display("FAIL borrow_sec got=%0d:%0d:%0d want=0:0:999", bus.minute, bus.second, bus.msecond);
    end
    n = 4;
    got = 1'b0;
    while (!got && n < 5000) begin
      clk_step();
      n++;
      if (bus.done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || n != 4000) begin
      failures++;
      $display("FAIL borrow_sec_done got=%0d (seen=%0b) want=4000", n, got);
    end
  endtask

  task automatic test_borrow_min();
    do_load(1, 0, 0);
    do_start();
    repeat (4) clk_step();
    checks++;
    if ({bus.minute, bus.second, bus.msecond} !== {8'd0, 8'd59, 16'd999}) begin
      failures++;
      $display("FAIL borrow_min got=%0d:%0d:%0d want=0:59:999", bus.minute, bus.second, bus.msecond);
    end
    do_clear();
    checks++;
    if ({bus.minute, bus.second, bus.msecond, bus.busy} !== 33'd0) begin
      failures++;
      $display("FAIL clear_run got=%0d:%0d:%0d busy=%b want=0:0:0 busy=0",
               bus.minute, bus.second, bus.msecond, bus.busy);
    end
    do_load(99, 75, 2000);
    checks++;
    if ({bus.minute, bus.second, bus.msecond} !== {8'd59, 8'd59, 16'd999}) begin
      failures++;
      $display("FAIL saturate got=%0d:%0d:%0d want=59:59:999", bus.minute, bus.second, bus.msecond);
    end
  endtask

  task automatic test_pause();
    int n;
    bit got;
    do_clear();
    do_load(0, 0, 5);
    do_start();
    repeat (6) clk_step();
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clk_step();
      checks++;
      if (bus.msecond !== 16'd4 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL pause_hold step=%0d got ms=%0d busy=%b want ms=4 busy=1",
                 i, bus.msecond, bus.busy);
      end
    end
    bus.pause = 1'b0;
    n = 16;
    got = 1'b0;
    while (!got && n < 80) begin
      clk_step();
      n++;
      if (bus.done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || n != 30) begin
      failures++;
      $display("FAIL pause_done_edge got=%0d (seen=%0b) want=30", n, got);
    end
  endtask

  task automatic test_zero_start();
    do_clear();
    do_start();
    checks++;
    if ({bus.busy, bus.done, bus.expired} !== 3'b011) begin
      failures++;
      $display("FAIL zero_start got busy/done/exp=%b want=011", {bus.busy, bus.done, bus.expired});
    end
    clk_step();
    checks++;
    if ({bus.busy, bus.done, bus.expired} !== 3'b001) begin
      failures++;
      $display("FAIL zero_start_after got busy/done/exp=%b want=001",
               {bus.busy, bus.done, bus.expired});
    end
    do_load(0, 0, 9);
    do_start();
    repeat (3) clk_step();
    bus.clear    = 1'b1;
    bus.load     = 1'b1;
    bus.load_min = 8'd2;
    bus.load_sec = 8'd3;
    bus.load_ms  = 16'd4;
    clk_step();
    idle_inputs();
    checks++;
    if ({bus.minute, bus.second, bus.msecond, bus.busy, bus.expired} !== 34'd0) begin
      failures++;
      $display("FAIL clear_over_load got=%0d:%0d:%0d busy=%b exp=%b want=0:0:0 busy=0 exp=0",
               bus.minute, bus.second, bus.msecond, bus.busy, bus.expired);
    end
    repeat (8) clk_step();
    checks++;
    if ({bus.minute, bus.second, bus.msecond, bus.busy} !== 33'd0) begin
      failures++;
      $display("FAIL clear_stays_idle got=%0d:%0d:%0d busy=%b want=0:0:0 busy=0",
               bus.minute, bus.second, bus.msecond, bus.busy);
    end
  endtask

  task automatic test_async_reset();
    logic [34:0] got;
    do_load(0, 0, 50);
    do_start();
    repeat (7) clk_step();
    #3 rst = 1'b0;
    #1;
    got = {bus.minute, bus.second, bus.msecond, bus.busy, bus.done, bus.expired};
    checks++;
    if (got !== 35'd0) begin
      failures++;
      $display("FAIL async_reset got=%h want=0", got);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    do_start();
    checks++;
    if ({bus.busy, bus.done, bus.expired} !== 3'b011) begin
      failures++;
      $display("FAIL post_reset_start got busy/done/exp=%b want=011",
               {bus.busy, bus.done, bus.expired});
    end
  endtask

  task automatic test_random();
    logic [31:0] want_cnt;
    logic [2:0]  want_st;
    for (int i = 0; i < 3000; i++) begin
      bus.clear = ($urandom_range(0, 99) < 2);
      bus.load  = ($urandom_range(0, 99) < 8);
      bus.start = ($urandom_range(0, 99) < 12);
      if ($urandom_range(0, 19) == 0) bus.pause = ~bus.pause;
      bus.load_min = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 100)) : 8'd0;
      bus.load_sec = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 100)) : 8'd0;
      bus.load_ms  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 2100))
                                                 : 16'($urandom_range(0, 12));
      clk_step();
      want_cnt = {8'(m_rem / 60000), 8'((m_rem / 1000) % 60), 16'(m_rem % 1000)};
      want_st  = {(m_state == MRun || m_state == MPause), m_done, (m_state == MDone)};
      checks++;
      if ({bus.minute, bus.second, bus.msecond} !== want_cnt) begin
        failures++;
        $display("FAIL rand_counts cyc=%0d got=%0d:%0d:%0d want=%0d:%0d:%0d", i,
                 bus.minute, bus.second, bus.msecond,
                 want_cnt[31:24], want_cnt[23:16], want_cnt[15:0]);
      end
      checks++;
      if ({bus.busy, bus.done, bus.expired} !== want_st) begin
        failures++;
        $display("FAIL rand_status cyc=%0d got busy/done/exp=%b want=%b", i,
                 {bus.busy, bus.done, bus.expired}, want_st);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_sec();
    test_borrow_min();
    test_pause();
    test_zero_start();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
